// File: rtl/text_stream_writer.sv
// ----------------------------------------------------------------------------
// text_stream_writer
//
// Character-stream sequencer for the VGA text overlay. ASCII characters are
// buffered in a small FIFO and handed one at a time to the glyph typer through
// a start/finish handshake, while a row/column cursor tracks where the next
// glyph lands. Newline (0x0A) moves the cursor to the start of the next row
// without touching the typer. Cursor-set commands are taken only while idle.
//
// Build option: define TEXT_WRAP_EN to wrap the cursor to the next row after
// the last column. Without it the column saturates one past the last column
// and further printable characters are discarded until a newline or command.
//
// Ports:
//   clock, resetn                   clock, async active-low reset
//   cmd_valid/ready, cmd_row/col    cursor-set request (clamped to screen)
//   char_valid/ready, char_data     character push into the FIFO
//   typer_start/row/col/char        glyph launch to the typer (held until finish)
//   typer_finish                    glyph stored by the typer
//   busy                            not idle or characters still queued
//   fifo_level                      characters currently queued
//   chars_written                   glyphs completed since reset (wraps)
// ----------------------------------------------------------------------------
module text_stream_writer #(
    parameter int unsigned COLS       = 80,
    parameter int unsigned ROWS       = 60,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [7:0]                        cmd_row,
    input  logic [7:0]                        cmd_col,
    input  logic                              char_valid,
    output logic                              char_ready,
    input  logic [7:0]                        char_data,
    output logic                              typer_start,
    output logic [7:0]                        typer_row,
    output logic [7:0]                        typer_col,
    output logic [7:0]                        typer_char,
    input  logic                              typer_finish,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic [31:0]                       chars_written
);

    localparam int unsigned   PtrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned   LvlW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);
    localparam logic [7:0]    RowLast = 8'(ROWS - 1);
    localparam logic [7:0]    ColLast = 8'(COLS - 1);
`ifndef TEXT_WRAP_EN
    localparam logic [7:0]    ColEnd  = 8'(COLS);
`endif

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StAdvance} state_e;

    state_e          state_q;
    logic [7:0]      row_q, col_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0] level_q;

    logic       push, pop;
    logic [7:0] head;
    logic [7:0] row_inc;
    logic [7:0] cmd_row_clamped, cmd_col_clamped;
    logic       col_past_end;

    always_comb begin
        cmd_ready       = (state_q == StIdle);
        char_ready      = (level_q != LvlFull);
        push            = char_valid && char_ready;
        // A pending command has priority over popping in IDLE.
        pop             = (state_q == StIdle) && !cmd_valid && (level_q != '0);
        head            = mem_q[rd_ptr_q];
        busy            = (state_q != StIdle) || (level_q != '0);
        fifo_level      = level_q;
        row_inc         = (row_q == RowLast) ? 8'd0 : row_q + 8'd1;
        cmd_row_clamped = (cmd_row > RowLast) ? RowLast : cmd_row;
        cmd_col_clamped = (cmd_col > ColLast) ? ColLast : cmd_col;
`ifdef TEXT_WRAP_EN
        col_past_end    = 1'b0;
`else
        col_past_end    = (col_q == ColEnd);
`endif
    end

    // Character storage; contents need no reset since level_q gates reads.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= char_data;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            row_q         <= '0;
            col_q         <= '0;
            typer_start   <= 1'b0;
            typer_row     <= '0;
            typer_col     <= '0;
            typer_char    <= '0;
            chars_written <= '0;
        end else begin
            typer_start <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        row_q <= cmd_row_clamped;
                        col_q <= cmd_col_clamped;
                    end else if (pop) begin
                        if (head == 8'h0A) begin
                            row_q <= row_inc;
                            col_q <= '0;
                        end else if (!col_past_end) begin
                            typer_row   <= row_q;
                            typer_col   <= col_q;
                            typer_char  <= head;
                            typer_start <= 1'b1;
                            state_q     <= StIssue;
                        end
                        // else: cursor past the end, character is dropped
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (typer_finish) begin
                        chars_written <= chars_written + 32'd1;
                        state_q       <= StAdvance;
                    end
                end
                StAdvance: begin
`ifdef TEXT_WRAP_EN
                    if (col_q == ColLast) begin
                        col_q <= '0;
                        row_q <= row_inc;
                    end else begin
                        col_q <= col_q + 8'd1;
                    end
`else
                    // Saturates at COLS: a glyph is only issued while col < COLS.
                    col_q <= col_q + 8'd1;
`endif
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_text_stream_writer.sv
// ----------------------------------------------------------------------------
// Bench for text_stream_writer (default geometry 80x60, 16-entry FIFO).
// A typer responder records every glyph launch and answers with a finish
// pulse after a random latency (or holds off while stalled). A reference
// model derives the expected glyph list and write count from the cursor rules.
// ----------------------------------------------------------------------------
module tb_text_stream_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int DEPTH = 16;

    logic        clock, resetn;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_row, cmd_col;
    logic        char_valid, char_ready;
    logic [7:0]  char_data;
    logic        typer_start, typer_finish;
    logic [7:0]  typer_row, typer_col, typer_char;
    logic        busy;
    logic [4:0]  fifo_level;
    logic [31:0] chars_written;

    logic fin_auto, fin_force, stall;
    assign typer_finish = fin_auto | fin_force;

    int          n_cmp, n_fail;
    logic [23:0] obs_q[$];
    logic [23:0] exp_q[$];
    int          m_row, m_col;
    int unsigned m_count;

    text_stream_writer #(.COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(DEPTH)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_row       (cmd_row),
        .cmd_col       (cmd_col),
        .char_valid    (char_valid),
        .char_ready    (char_ready),
        .char_data     (char_data),
        .typer_start   (typer_start),
        .typer_row     (typer_row),
        .typer_col     (typer_col),
        .typer_char    (typer_char),
        .typer_finish  (typer_finish),
        .busy          (busy),
        .fifo_level    (fifo_level),
        .chars_written (chars_written)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Typer stand-in: one glyph at a time, finish only while the DUT waits.
    initial begin
        fin_auto = 1'b0;
        forever begin
            @(negedge clock);
            if (resetn && typer_start) begin
                obs_q.push_back({typer_row, typer_col, typer_char});
                repeat (1 + $urandom_range(0, 3)) @(negedge clock);
                while (stall && resetn) @(negedge clock);
                if (resetn) begin
                    check("typer_hold", {typer_row, typer_col, typer_char},
                          obs_q[obs_q.size() - 1]);
                    fin_auto = 1'b1;
                    @(negedge clock);
                    fin_auto = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_row   = 0;
        m_col   = 0;
        m_count = 0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic model_cmd(input int r, input int c);
        m_row = (r >= ROWS) ? ROWS - 1 : r;
        m_col = (c >= COLS) ? COLS - 1 : c;
    endtask

    task automatic model_char(input logic [7:0] c);
        if (c == 8'h0A) begin
            m_row = (m_row + 1) % ROWS;
            m_col = 0;
        end else if (m_col < COLS) begin
            exp_q.push_back({8'(m_row), 8'(m_col), c});
            m_count++;
`ifdef TEXT_WRAP_EN
            if (m_col + 1 == COLS) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
            end else begin
                m_col++;
            end
`else
            m_col++;
`endif
        end
    endtask

    // ---------------- stimulus helpers (entered/left at posedge+1) ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input int r, input int c);
        cmd_row   = 8'(r);
        cmd_col   = 8'(c);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        model_cmd(r, c);
    endtask

    task automatic push_char(input logic [7:0] c);
        int   n   = 0;
        logic acc = 1'b0;
        char_data  = c;
        char_valid = 1'b1;
        while (!acc && n < 500) begin
            acc = char_ready;
            tick();
            n++;
        end
        char_valid = 1'b0;
        check("push_accept", acc, 1'b1);
        model_char(c);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic compare_glyphs(input string tag);
        int n;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_glyph"}, obs_q[i], exp_q[i]);
        end
        check({tag, "_written"}, chars_written, m_count);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, typer_start, 1'b0);
        check({tag, "_glyph"}, {typer_row, typer_col, typer_char}, 24'h0);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        check({tag, "_char_ready"}, char_ready, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_level"}, fifo_level, 5'd0);
        check({tag, "_written"}, chars_written, 32'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [7:0] c;
        int         len;
        n_cmp      = 0;
        n_fail     = 0;
        resetn     = 1'b0;
        cmd_valid  = 1'b0;
        cmd_row    = '0;
        cmd_col    = '0;
        char_valid = 1'b0;
        char_data  = '0;
        fin_force  = 1'b0;
        stall      = 1'b0;
        model_reset();

        #12;
        check_reset_outputs("reset");
        #1 resetn = 1'b1;
        tick();

        // "AB" at (2,5) with first-glyph latency
        send_cmd(2, 5);
        push_char(8'h41);
        check("ab_start_early", typer_start, 1'b0);
        check("ab_level1", fifo_level, 5'd1);
        push_char(8'h42);
        check("ab_start", typer_start, 1'b1);
        check("ab_level_pushpop", fifo_level, 5'd1);
        wait_idle(500);
        compare_glyphs("ab");
        check("ab_busy", busy, 1'b0);

        // Fill FIFO while a held command blocks pops
        stall     = 1'b1;
        cmd_row   = 8'd0;
        cmd_col   = 8'd0;
        cmd_valid = 1'b1;
        model_cmd(0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            push_char(8'($urandom_range(32, 126)));
        end
        check("full_ready", char_ready, 1'b0);
        check("full_level", fifo_level, 5'd16);
        c          = 8'($urandom_range(32, 126));
        char_data  = c;
        char_valid = 1'b1;
        repeat (3) tick();
        check("full_held_level", fifo_level, 5'd16);
        cmd_valid = 1'b0;
        tick();
        check("full_pop_level", fifo_level, 5'd15);
        check("full_pop_start", typer_start, 1'b1);
        tick();
        check("full_17th_level", fifo_level, 5'd16);
        char_valid = 1'b0;
        model_char(c);
        stall = 1'b0;
        wait_idle(2000);
        compare_glyphs("full");

        // End-of-row behaviour
        send_cmd(3, 78);
        push_char(8'h58);
        push_char(8'h59);
        push_char(8'h5A);
        wait_idle(500);
        compare_glyphs("eol");

        // Newline on the last row wraps to row 0
        send_cmd(59, 10);
        push_char(8'h0A);
        push_char(8'h51);
        wait_idle(500);
        compare_glyphs("nl");

        // Command clamping, then a finish pulse while idle
        send_cmd(200, 200);
        push_char(8'h43);
        wait_idle(500);
        compare_glyphs("clamp");
        fin_force = 1'b1;
        tick();
        fin_force = 1'b0;
        tick();
        check("idle_finish_written", chars_written, m_count);
        check("idle_finish_busy", busy, 1'b0);

        // Reset mid-glyph with 4 characters queued
        send_cmd(0, 0);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_char(8'h61 + 8'(i));
        end
        tick();
        tick();
        check("rst_pre_level", fifo_level, 5'd4);
        check("rst_pre_busy", busy, 1'b1);
        resetn = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clock);
        #1 resetn = 1'b1;
        model_reset();
        stall = 1'b0;
        tick();
        fin_force = 1'b1;
        tick();
        fin_force = 1'b0;
        tick();
        check_reset_outputs("rst_stale");

        // Random commands and strings
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) != 0) begin
                send_cmd($urandom_range(0, 70), $urandom_range(70, 90) - $urandom_range(0, 1) * 60);
            end
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 9) == 0) c = 8'h0A;
                else c = 8'($urandom_range(32, 126));
                push_char(c);
            end
            wait_idle(2000);
            compare_glyphs("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
